// File: rtl/timer_alarm_pkg.sv
// Shared types and constants for the timer alarm scheduler.
//   state_e     : scheduler FSM states
//   RESP_*      : AXI4-Lite response codes
//   DEF_*       : default timer register map and ctrl words
//   is_due()    : true when a modular tick delta has reached or passed zero
package timer_alarm_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_NOW,
    ST_SCAN,
    ST_PROG,
    ST_VERIFY
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_VAL_ADDR   = 32'h0000_0010;
  localparam logic [31:0] DEF_CMP_ADDR   = 32'h0000_000C;
  localparam logic [31:0] DEF_CTRL_ADDR  = 32'h0000_0008;
  localparam logic [31:0] DEF_CTRL_ARMED = 32'h0000_0003;
  localparam logic [31:0] DEF_CTRL_IDLE  = 32'h0000_0001;

  // A deadline is due when deadline - now (mod 2^32) is zero or has the sign
  // bit set, i.e. it lies at most 2^31 ticks in the past.
  function automatic logic is_due(input logic [31:0] delta);
    return (delta == 32'h0) || delta[31];
  endfunction

endpackage

// File: rtl/timer_alarm_axil_mst.sv
// Single-outstanding AXI4-Lite master.
//   req/write/addr/wdata : start one transaction (only while no transaction is open)
//   done                 : one-cycle pulse when the response has been taken
//   rdata                : read data, valid together with done after a read
//   cfg_*                : AXI4-Lite master channels; AW and W handshake independently,
//                          B is accepted only once both have completed.
// Response codes are not acted on; the caller always sees done.
module timer_alarm_axil_mst (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        cfg_awvalid_o,
  output logic [31:0] cfg_awaddr_o,
  input  logic        cfg_awready_i,
  output logic        cfg_wvalid_o,
  output logic [31:0] cfg_wdata_o,
  output logic [3:0]  cfg_wstrb_o,
  input  logic        cfg_wready_i,
  input  logic        cfg_bvalid_i,
  input  logic [1:0]  cfg_bresp_i,
  output logic        cfg_bready_o,
  output logic        cfg_arvalid_o,
  output logic [31:0] cfg_araddr_o,
  input  logic        cfg_arready_i,
  input  logic        cfg_rvalid_i,
  input  logic [31:0] cfg_rdata_i,
  input  logic [1:0]  cfg_rresp_i,
  output logic        cfg_rready_o
);

  assign cfg_wstrb_o = 4'hF;

  // The last open address/data channel completes at the coming edge.
  logic aw_w_last;
  assign aw_w_last = (cfg_awvalid_o || cfg_wvalid_o) &&
                     (!cfg_awvalid_o || cfg_awready_i) &&
                     (!cfg_wvalid_o  || cfg_wready_i);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done          <= 1'b0;
      rdata         <= 32'h0;
      cfg_awvalid_o <= 1'b0;
      cfg_awaddr_o  <= 32'h0;
      cfg_wvalid_o  <= 1'b0;
      cfg_wdata_o   <= 32'h0;
      cfg_bready_o  <= 1'b0;
      cfg_arvalid_o <= 1'b0;
      cfg_araddr_o  <= 32'h0;
      cfg_rready_o  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (req && write) begin
        cfg_awvalid_o <= 1'b1;
        cfg_wvalid_o  <= 1'b1;
        cfg_awaddr_o  <= addr;
        cfg_wdata_o   <= wdata;
      end
      if (req && !write) begin
        cfg_arvalid_o <= 1'b1;
        cfg_araddr_o  <= addr;
        cfg_rready_o  <= 1'b1;
      end
      if (cfg_awvalid_o && cfg_awready_i) cfg_awvalid_o <= 1'b0;
      if (cfg_wvalid_o && cfg_wready_i)   cfg_wvalid_o  <= 1'b0;
      if (aw_w_last) cfg_bready_o <= 1'b1;
      if (cfg_bready_o && cfg_bvalid_i) begin
        cfg_bready_o <= 1'b0;
        done         <= 1'b1;
      end
      if (cfg_arvalid_o && cfg_arready_i) cfg_arvalid_o <= 1'b0;
      if (cfg_rready_o && cfg_rvalid_i) begin
        cfg_rready_o <= 1'b0;
        rdata        <= cfg_rdata_i;
        done         <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_alarm_sched.sv
// Multiplexes NUM_SLOTS software alarms onto one timer compare channel.
//   arm_*     : arm (deadline) or cancel a slot; accepted only while idle
//   expire_*  : lowest-numbered expired slot, popped on valid && ready
//   irq_i     : timer interrupt (level), triggers a rescan
//   cfg_*     : AXI4-Lite master to the timer register block
//   busy_o    : scheduler FSM not idle
// Optional macro TIMER_ALARM_PERIODIC_EN adds arm_period_i and periodic reload.
module timer_alarm_sched
  import timer_alarm_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter logic [31:0] VAL_ADDR   = DEF_VAL_ADDR,
  parameter logic [31:0] CMP_ADDR   = DEF_CMP_ADDR,
  parameter logic [31:0] CTRL_ADDR  = DEF_CTRL_ADDR,
  parameter logic [31:0] CTRL_ARMED = DEF_CTRL_ARMED,
  parameter logic [31:0] CTRL_IDLE  = DEF_CTRL_IDLE
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         arm_valid_i,
  output logic                         arm_ready_o,
  input  logic [$clog2(NUM_SLOTS)-1:0] arm_id_i,
  input  logic                         arm_cancel_i,
  input  logic [31:0]                  arm_deadline_i,
`ifdef TIMER_ALARM_PERIODIC_EN
  input  logic [31:0]                  arm_period_i,
`endif
  output logic                         expire_valid_o,
  output logic [$clog2(NUM_SLOTS)-1:0] expire_id_o,
  input  logic                         expire_ready_i,
  input  logic                         irq_i,
  output logic                         cfg_awvalid_o,
  output logic [31:0]                  cfg_awaddr_o,
  input  logic                         cfg_awready_i,
  output logic                         cfg_wvalid_o,
  output logic [31:0]                  cfg_wdata_o,
  output logic [3:0]                   cfg_wstrb_o,
  input  logic                         cfg_wready_i,
  input  logic                         cfg_bvalid_i,
  input  logic [1:0]                   cfg_bresp_i,
  output logic                         cfg_bready_o,
  output logic                         cfg_arvalid_o,
  output logic [31:0]                  cfg_araddr_o,
  input  logic                         cfg_arready_i,
  input  logic                         cfg_rvalid_i,
  input  logic [31:0]                  cfg_rdata_i,
  input  logic [1:0]                   cfg_rresp_i,
  output logic                         cfg_rready_o,
  output logic                         busy_o
);

  localparam int unsigned IW = $clog2(NUM_SLOTS);

  state_e                 state, state_n;
  logic                   pend, prog_step;
  logic [31:0]            now;
  logic [IW-1:0]          scan_idx;
  logic                   min_found;
  logic [31:0]            min_delta, min_deadline;
  logic [NUM_SLOTS-1:0]   active, expired, exp_n;
  logic [31:0]            deadline [NUM_SLOTS];
`ifdef TIMER_ALARM_PERIODIC_EN
  logic [31:0]            period [NUM_SLOTS];
  logic [31:0]            reload_deadline;
`endif

  logic        req, req_write, done;
  logic [31:0] req_addr, req_wdata, mst_rdata;
  logic        arm_fire;
  logic [31:0] cur_deadline, cur_delta, cand_delta, cand_deadline;
  logic        cur_due, cand_valid, reload, take;

  assign arm_fire = arm_valid_i && arm_ready_o;
  assign busy_o   = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_INIT;
    else         state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_n     = state;
    arm_ready_o = 1'b0;
    req         = 1'b0;
    req_write   = 1'b1;
    req_addr    = CTRL_ADDR;
    req_wdata   = CTRL_IDLE;
    case (state)
      ST_INIT: begin
        req = !pend;
        if (done) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        arm_ready_o = 1'b1;
        if (arm_valid_i || irq_i) state_n = ST_RD_NOW;
      end
      ST_RD_NOW: begin
        req       = !pend;
        req_write = 1'b0;
        req_addr  = VAL_ADDR;
        if (done) state_n = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_idx == IW'(NUM_SLOTS - 1)) state_n = ST_PROG;
      end
      ST_PROG: begin
        // Step 0 writes CMP when an alarm was chosen; the ctrl write is last.
        req = !pend;
        if (min_found && !prog_step) begin
          req_addr  = CMP_ADDR;
          req_wdata = min_deadline;
        end else if (min_found) begin
          req_wdata = CTRL_ARMED;
        end
        if (done && !(min_found && !prog_step)) state_n = ST_VERIFY;
      end
      ST_VERIFY: begin
        // Re-read the counter: if it already passed the programmed deadline
        // the compare may have been missed, so rescan with the fresh value.
        if (!min_found) begin
          state_n = ST_IDLE;
        end else begin
          req       = !pend;
          req_write = 1'b0;
          req_addr  = VAL_ADDR;
          if (done) state_n = is_due(min_deadline - mst_rdata) ? ST_SCAN : ST_IDLE;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  // Slot under evaluation during SCAN and its candidacy for the next compare.
  always_comb begin
    cur_deadline  = deadline[scan_idx];
    cur_delta     = cur_deadline - now;
    cur_due       = active[scan_idx] && is_due(cur_delta);
    cand_valid    = active[scan_idx] && !cur_due;
    cand_delta    = cur_delta;
    cand_deadline = cur_deadline;
`ifdef TIMER_ALARM_PERIODIC_EN
    reload          = cur_due && (period[scan_idx] != 32'h0);
    reload_deadline = cur_deadline + period[scan_idx];
    if (reload) begin
      cand_deadline = reload_deadline;
      cand_delta    = reload_deadline - now;
      cand_valid    = !is_due(cand_delta);
    end
`else
    reload = 1'b0;
`endif
    // Strict less-than keeps the lowest index on equal deltas.
    take = cand_valid && (!min_found || (cand_delta < min_delta));
  end

  always_comb begin
    exp_n = expired;
    if (expire_valid_o && expire_ready_i) exp_n[expire_id_o] = 1'b0;
    if (arm_fire) exp_n[arm_id_i] = 1'b0;
    if (state == ST_SCAN && cur_due) exp_n[scan_idx] = 1'b1;
  end

  always_comb begin
    expire_id_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (expired[i]) expire_id_o = IW'(i);
    end
  end
  assign expire_valid_o = |expired;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend         <= 1'b0;
      prog_step    <= 1'b0;
      now          <= 32'h0;
      scan_idx     <= '0;
      min_found    <= 1'b0;
      min_delta    <= 32'h0;
      min_deadline <= 32'h0;
      active       <= '0;
      expired      <= '0;
    end else begin
      expired <= exp_n;
      if (req)       pend <= 1'b1;
      else if (done) pend <= 1'b0;
      if (done && (state == ST_RD_NOW || state == ST_VERIFY)) now <= mst_rdata;
      prog_step <= (state == ST_PROG) && (prog_step || done);
      if (arm_fire) active[arm_id_i] <= !arm_cancel_i;
      if (state_n == ST_SCAN && state != ST_SCAN) begin
        scan_idx  <= '0;
        min_found <= 1'b0;
      end else if (state == ST_SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        if (cur_due && !reload) active[scan_idx] <= 1'b0;
        if (take) begin
          min_found    <= 1'b1;
          min_delta    <= cand_delta;
          min_deadline <= cand_deadline;
        end
      end
    end
  end

  // NOTE: slot storage has no reset; a slot's contents only matter once its
  // active bit (which is reset) has been set by an arm.
  always_ff @(posedge clk_i) begin
    if (arm_fire && !arm_cancel_i) begin
      deadline[arm_id_i] <= arm_deadline_i;
`ifdef TIMER_ALARM_PERIODIC_EN
      period[arm_id_i]   <= arm_period_i;
`endif
    end
`ifdef TIMER_ALARM_PERIODIC_EN
    if (state == ST_SCAN && reload) deadline[scan_idx] <= reload_deadline;
`endif
  end

  timer_alarm_axil_mst u_axil (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req           (req),
    .write         (req_write),
    .addr          (req_addr),
    .wdata         (req_wdata),
    .done          (done),
    .rdata         (mst_rdata),
    .cfg_awvalid_o (cfg_awvalid_o),
    .cfg_awaddr_o  (cfg_awaddr_o),
    .cfg_awready_i (cfg_awready_i),
    .cfg_wvalid_o  (cfg_wvalid_o),
    .cfg_wdata_o   (cfg_wdata_o),
    .cfg_wstrb_o   (cfg_wstrb_o),
    .cfg_wready_i  (cfg_wready_i),
    .cfg_bvalid_i  (cfg_bvalid_i),
    .cfg_bresp_i   (cfg_bresp_i),
    .cfg_bready_o  (cfg_bready_o),
    .cfg_arvalid_o (cfg_arvalid_o),
    .cfg_araddr_o  (cfg_araddr_o),
    .cfg_arready_i (cfg_arready_i),
    .cfg_rvalid_i  (cfg_rvalid_i),
    .cfg_rdata_i   (cfg_rdata_i),
    .cfg_rresp_i   (cfg_rresp_i),
    .cfg_rready_o  (cfg_rready_o)
  );

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Directed bench for timer_alarm_sched with a behavioural AXI4-Lite timer
// slave. The slave logs every completed write and answers VAL reads with
// tb_now; expected values below are worked out by hand.
`timescale 1ns/1ps
module tb_timer_alarm_sched;
  import timer_alarm_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        arm_valid_i, arm_ready_o, arm_cancel_i;
  logic [1:0]  arm_id_i;
  logic [31:0] arm_deadline_i;
`ifdef TIMER_ALARM_PERIODIC_EN
  logic [31:0] arm_period_i;
`endif
  logic        expire_valid_o, expire_ready_i, irq_i, busy_o;
  logic [1:0]  expire_id_o;
  logic        cfg_awvalid_o, cfg_awready_i, cfg_wvalid_o, cfg_wready_i;
  logic [31:0] cfg_awaddr_o, cfg_wdata_o, cfg_araddr_o, cfg_rdata_i;
  logic [3:0]  cfg_wstrb_o;
  logic        cfg_bvalid_i, cfg_bready_o, cfg_arvalid_o, cfg_arready_i;
  logic        cfg_rvalid_i, cfg_rready_o;
  logic [1:0]  cfg_bresp_i, cfg_rresp_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  timer_alarm_sched dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .arm_valid_i    (arm_valid_i),
    .arm_ready_o    (arm_ready_o),
    .arm_id_i       (arm_id_i),
    .arm_cancel_i   (arm_cancel_i),
    .arm_deadline_i (arm_deadline_i),
`ifdef TIMER_ALARM_PERIODIC_EN
    .arm_period_i   (arm_period_i),
`endif
    .expire_valid_o (expire_valid_o),
    .expire_id_o    (expire_id_o),
    .expire_ready_i (expire_ready_i),
    .irq_i          (irq_i),
    .cfg_awvalid_o  (cfg_awvalid_o),
    .cfg_awaddr_o   (cfg_awaddr_o),
    .cfg_awready_i  (cfg_awready_i),
    .cfg_wvalid_o   (cfg_wvalid_o),
    .cfg_wdata_o    (cfg_wdata_o),
    .cfg_wstrb_o    (cfg_wstrb_o),
    .cfg_wready_i   (cfg_wready_i),
    .cfg_bvalid_i   (cfg_bvalid_i),
    .cfg_bresp_i    (cfg_bresp_i),
    .cfg_bready_o   (cfg_bready_o),
    .cfg_arvalid_o  (cfg_arvalid_o),
    .cfg_araddr_o   (cfg_araddr_o),
    .cfg_arready_i  (cfg_arready_i),
    .cfg_rvalid_i   (cfg_rvalid_i),
    .cfg_rdata_i    (cfg_rdata_i),
    .cfg_rresp_i    (cfg_rresp_i),
    .cfg_rready_o   (cfg_rready_o),
    .busy_o         (busy_o)
  );

  // ---------------- timer slave model ----------------
  logic [31:0] tb_now = 32'h0;
  logic [31:0] race_step = 32'h0;
  logic [31:0] cmp_reg, ctrl_reg;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          aw_delay = 0, w_delay = 0;
  int          bready_early = 0;

  initial begin
    int aw_cnt, w_cnt, r_lat;
    bit aw_done, w_done, ar_done;
    bit p_aw_hs, p_w_hs, p_b_hs, p_ar_hs, p_r_hs;
    logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
    cfg_awready_i = 1'b0; cfg_wready_i = 1'b0; cfg_bvalid_i = 1'b0;
    cfg_arready_i = 1'b0; cfg_rvalid_i = 1'b0; cfg_rdata_i = 32'h0;
    cfg_bresp_i = RESP_SLVERR; cfg_rresp_i = RESP_OKAY;
    aw_cnt = 0; w_cnt = 0; r_lat = 0;
    aw_done = 0; w_done = 0; ar_done = 0;
    p_aw_hs = 0; p_w_hs = 0; p_b_hs = 0; p_ar_hs = 0; p_r_hs = 0;
    aw_addr_l = 0; w_data_l = 0; ar_addr_l = 0;
    cmp_reg = 32'h0; ctrl_reg = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        cfg_awready_i = 1'b0; cfg_wready_i = 1'b0; cfg_bvalid_i = 1'b0;
        cfg_arready_i = 1'b0; cfg_rvalid_i = 1'b0;
        aw_cnt = 0; w_cnt = 0; aw_done = 0; w_done = 0; ar_done = 0;
        p_aw_hs = 0; p_w_hs = 0; p_b_hs = 0; p_ar_hs = 0; p_r_hs = 0;
      end else begin
        // Handshakes that completed at the rising edge just passed.
        if (p_aw_hs) begin aw_done = 1; cfg_awready_i = 1'b0; end
        if (p_w_hs)  begin w_done = 1;  cfg_wready_i = 1'b0; end
        if (p_b_hs)  begin cfg_bvalid_i = 1'b0; aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0; end
        if (p_ar_hs) begin ar_done = 1; cfg_arready_i = 1'b0; r_lat = $urandom_range(0, 3); end
        if (p_r_hs)  begin cfg_rvalid_i = 1'b0; ar_done = 0; end
        if (cfg_bready_o && !(aw_done && w_done)) bready_early++;
        if (cfg_awvalid_o && !aw_done && !cfg_awready_i) begin
          if (aw_cnt >= aw_delay) begin cfg_awready_i = 1'b1; aw_addr_l = cfg_awaddr_o; end
          else aw_cnt++;
        end
        if (cfg_wvalid_o && !w_done && !cfg_wready_i) begin
          if (w_cnt >= w_delay) begin cfg_wready_i = 1'b1; w_data_l = cfg_wdata_o; end
          else w_cnt++;
        end
        if (aw_done && w_done && !cfg_bvalid_i) begin
          cfg_bvalid_i = 1'b1;
          wlog_addr.push_back(aw_addr_l);
          wlog_data.push_back(w_data_l);
          if (aw_addr_l == DEF_CMP_ADDR)  cmp_reg  = w_data_l;
          if (aw_addr_l == DEF_CTRL_ADDR) ctrl_reg = w_data_l;
        end
        if (cfg_arvalid_o && !ar_done && !cfg_arready_i && ($urandom_range(0, 1) == 1)) begin
          cfg_arready_i = 1'b1;
          ar_addr_l = cfg_araddr_o;
        end
        if (ar_done && !cfg_rvalid_i) begin
          if (r_lat == 0) begin
            cfg_rvalid_i = 1'b1;
            cfg_rdata_i  = (ar_addr_l == DEF_VAL_ADDR) ? tb_now :
                           (ar_addr_l == DEF_CMP_ADDR) ? cmp_reg : ctrl_reg;
            if (ar_addr_l == DEF_VAL_ADDR) tb_now = tb_now + race_step;
          end else begin
            r_lat--;
          end
        end
        p_aw_hs = cfg_awvalid_o && cfg_awready_i;
        p_w_hs  = cfg_wvalid_o && cfg_wready_i;
        p_b_hs  = cfg_bvalid_i && cfg_bready_o;
        p_ar_hs = cfg_arvalid_o && cfg_arready_i;
        p_r_hs  = cfg_rvalid_i && cfg_rready_o;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write 'back' entries before the newest must be (addr, data).
  task automatic check_wr(input string tag, input int back,
                          input logic [31:0] addr, input logic [31:0] data);
    int idx;
    idx = wlog_addr.size() - 1 - back;
    if (idx < 0) begin
      check({tag, "_present"}, 32'(wlog_addr.size()), 32'(back + 1));
    end else begin
      check({tag, "_addr"}, wlog_addr[idx], addr);
      check({tag, "_data"}, wlog_data[idx], data);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) check("idle_timeout", 32'(busy_o), 32'h0);
  endtask

  task automatic arm(input logic [1:0] id, input logic cancel,
                     input logic [31:0] dl, input logic [31:0] per);
    int n;
    arm_id_i = id; arm_cancel_i = cancel; arm_deadline_i = dl;
`ifdef TIMER_ALARM_PERIODIC_EN
    arm_period_i = per;
`else
    if (per != 32'h0) $display("note: period ignored in one-shot build");
`endif
    arm_valid_i = 1'b1;
    n = 0;
    while (!arm_ready_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (!arm_ready_o) check("arm_ready_timeout", 32'(arm_ready_o), 32'h1);
    @(negedge clk_i);
    arm_valid_i = 1'b0;
    wait_idle();
  endtask

  task automatic pulse_irq();
    int n;
    irq_i = 1'b1;
    @(negedge clk_i);
    n = 0;
    while (!busy_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    irq_i = 1'b0;
    if (!busy_o) check("irq_start_timeout", 32'(busy_o), 32'h1);
    wait_idle();
  endtask

  task automatic pop();
    expire_ready_i = 1'b1;
    @(negedge clk_i);
    expire_ready_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int mark;
    arm_valid_i = 1'b0; arm_id_i = 2'd0; arm_cancel_i = 1'b0; arm_deadline_i = 32'h0;
`ifdef TIMER_ALARM_PERIODIC_EN
    arm_period_i = 32'h0;
`endif
    expire_ready_i = 1'b0; irq_i = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk_i);
    check("rst_awvalid", 32'(cfg_awvalid_o), 32'h0);
    check("rst_wvalid",  32'(cfg_wvalid_o),  32'h0);
    check("rst_arvalid", 32'(cfg_arvalid_o), 32'h0);
    check("rst_bready",  32'(cfg_bready_o),  32'h0);
    check("rst_rready",  32'(cfg_rready_o),  32'h0);
    check("rst_awaddr",  cfg_awaddr_o, 32'h0);
    check("rst_wdata",   cfg_wdata_o,  32'h0);
    check("rst_wstrb",   32'(cfg_wstrb_o), 32'hF);
    check("rst_expire",  32'(expire_valid_o), 32'h0);
    check("rst_arm_rdy", 32'(arm_ready_o), 32'h0);
    check("rst_busy",    32'(busy_o), 32'h1);

    // INIT writes CTRL_IDLE exactly once.
    rst_ni = 1'b1;
    @(negedge clk_i);
    wait_idle();
    repeat (5) @(negedge clk_i);
    check("init_nwr", 32'(wlog_addr.size()), 32'd1);
    check_wr("init_wr", 0, 32'h8, 32'h1);
    check("init_busy", 32'(busy_o), 32'h0);
    check("init_expire", 32'(expire_valid_o), 32'h0);

    // Earliest of two alarms is programmed.
    tb_now = 32'd100;
    arm(2'd2, 1'b0, 32'd500, 32'd0);
    check_wr("arm2_cmp", 1, 32'hC, 32'd500);
    check_wr("arm2_ctrl", 0, 32'h8, 32'h3);
    mark = wlog_addr.size();
    arm(2'd1, 1'b0, 32'd300, 32'd0);
    check("arm1_nwr", 32'(wlog_addr.size() - mark), 32'd2);
    check_wr("arm1_cmp", 1, 32'hC, 32'd300);
    check_wr("arm1_ctrl", 0, 32'h8, 32'h3);
    check("arm1_noexp", 32'(expire_valid_o), 32'h0);

    // Interrupt at 300: slot 1 expires, slot 2 becomes the compare.
    tb_now = 32'd300;
    pulse_irq();
    check("irq300_valid", 32'(expire_valid_o), 32'h1);
    check("irq300_id", 32'(expire_id_o), 32'd1);
    check_wr("irq300_cmp", 1, 32'hC, 32'd500);
    check_wr("irq300_ctrl", 0, 32'h8, 32'h3);
    pop();
    check("irq300_pop", 32'(expire_valid_o), 32'h0);

    // Cancel the remaining alarm: only CTRL_IDLE is written.
    mark = wlog_addr.size();
    arm(2'd2, 1'b1, 32'd0, 32'd0);
    check("cancel2_nwr", 32'(wlog_addr.size() - mark), 32'd1);
    check_wr("cancel2_ctrl", 0, 32'h8, 32'h1);

    // Deadline across counter wrap is in the future (delta 32).
    tb_now = 32'hFFFF_FFF0;
    arm(2'd0, 1'b0, 32'h0000_0010, 32'd0);
    check_wr("wrap_cmp", 1, 32'hC, 32'h10);
    check_wr("wrap_ctrl", 0, 32'h8, 32'h3);
    check("wrap_noexp", 32'(expire_valid_o), 32'h0);
    arm(2'd0, 1'b1, 32'd0, 32'd0);

    // Deadline already in the past expires in the first scan.
    tb_now = 32'd1000;
    mark = wlog_addr.size();
    arm(2'd3, 1'b0, 32'd995, 32'd0);
    check("past_valid", 32'(expire_valid_o), 32'h1);
    check("past_id", 32'(expire_id_o), 32'd3);
    check("past_nwr", 32'(wlog_addr.size() - mark), 32'd1);
    check_wr("past_ctrl", 0, 32'h8, 32'h1);
    pop();

    // Two simultaneous expiries, consumer stalled.
    tb_now = 32'd2000;
    arm(2'd0, 1'b0, 32'd2100, 32'd0);
    arm(2'd3, 1'b0, 32'd2100, 32'd0);
    check_wr("dual_cmp", 1, 32'hC, 32'd2100);
    tb_now = 32'd2100;
    pulse_irq();
    check("dual_first", 32'(expire_id_o), 32'd0);
    repeat (10) @(negedge clk_i);
    check("dual_hold_valid", 32'(expire_valid_o), 32'h1);
    check("dual_hold_id", 32'(expire_id_o), 32'd0);
    pop();
    check("dual_second_valid", 32'(expire_valid_o), 32'h1);
    check("dual_second_id", 32'(expire_id_o), 32'd3);
    pop();
    check("dual_empty", 32'(expire_valid_o), 32'h0);
    check_wr("dual_ctrl", 0, 32'h8, 32'h1);

    // Slow AW channel, fast W channel.
    aw_delay = 3; w_delay = 0;
    tb_now = 32'd3000;
    mark = wlog_addr.size();
    arm(2'd1, 1'b0, 32'd3500, 32'd0);
    check("stall_nwr", 32'(wlog_addr.size() - mark), 32'd2);
    check_wr("stall_cmp", 1, 32'hC, 32'd3500);
    check_wr("stall_ctrl", 0, 32'h8, 32'h3);
    mark = wlog_addr.size();
    arm(2'd2, 1'b0, 32'd3200, 32'd0);
    check("stall2_nwr", 32'(wlog_addr.size() - mark), 32'd2);
    check_wr("stall2_cmp", 1, 32'hC, 32'd3200);
    arm(2'd1, 1'b1, 32'd0, 32'd0);
    arm(2'd2, 1'b1, 32'd0, 32'd0);
    check_wr("stall_cancel", 0, 32'h8, 32'h1);
    aw_delay = 0;

    // Counter advances between scan and program: VERIFY must catch it.
    tb_now = 32'd4000;
    race_step = 32'd100;
    mark = wlog_addr.size();
    arm(2'd0, 1'b0, 32'd4050, 32'd0);
    race_step = 32'd0;
    check("race_valid", 32'(expire_valid_o), 32'h1);
    check("race_id", 32'(expire_id_o), 32'd0);
    check("race_nwr", 32'(wlog_addr.size() - mark), 32'd3);
    check_wr("race_cmp", 2, 32'hC, 32'd4050);
    check_wr("race_ctrl", 0, 32'h8, 32'h1);
    pop();

`ifdef TIMER_ALARM_PERIODIC_EN
    // Period 50 from deadline 200: expiries at 200, 250, 300.
    tb_now = 32'd150;
    arm(2'd1, 1'b0, 32'd200, 32'd50);
    check_wr("per_cmp0", 1, 32'hC, 32'd200);
    tb_now = 32'd200;
    pulse_irq();
    check("per200_id", 32'(expire_id_o), 32'd1);
    check_wr("per200_cmp", 1, 32'hC, 32'd250);
    pop();
    tb_now = 32'd250;
    pulse_irq();
    check("per250_valid", 32'(expire_valid_o), 32'h1);
    check_wr("per250_cmp", 1, 32'hC, 32'd300);
    pop();
    tb_now = 32'd300;
    pulse_irq();
    check("per300_valid", 32'(expire_valid_o), 32'h1);
    check_wr("per300_cmp", 1, 32'hC, 32'd350);
    pop();
    arm(2'd1, 1'b1, 32'd0, 32'd0);
`endif

    check("bready_early", 32'(bready_early), 32'h0);
    check("final_busy", 32'(busy_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_alarm_sched.md
Name: timer_alarm_sched

Overview:
- Multiplexes NUM_SLOTS software alarms onto one hardware timer channel (counter, compare and ctrl registers) of the system tick timer.
- Holds each alarm deadline and finds the earliest pending one.
- Programs the timer's compare and ctrl registers over an AXI4-Lite master port, services the timer interrupt, and reports expired alarms through a handshake.
- Sits between the CPU/peripheral requesters and the timer's cfg slave port.

Parameters:
- NUM_SLOTS, 4, number of alarm slots (2..16).
- VAL_ADDR, 32'h0000_0010, timer current-value register address.
- CMP_ADDR, 32'h0000_000C, timer compare register address.
- CTRL_ADDR, 32'h0000_0008, timer ctrl register address.
- CTRL_ARMED, 32'h3, ctrl word written when an alarm is pending (enable and interrupt).
- CTRL_IDLE, 32'h1, ctrl word written when no alarm is pending (enable only).

Ports:
- clk_i in 1: clock.
- rst_ni in 1: reset, asynchronous, active-low.
- arm_valid_i in 1: arm/cancel request.
- arm_ready_o out 1: request accepted.
- arm_id_i in $clog2(NUM_SLOTS): slot index.
- arm_cancel_i in 1: 1 = cancel slot, 0 = arm slot.
- arm_deadline_i in 32: absolute tick deadline.
- expire_valid_o out 1: an expired alarm is available.
- expire_id_o out $clog2(NUM_SLOTS): id of the expired slot.
- expire_ready_i in 1: consumer accepts the expiry.
- irq_i in 1: timer interrupt output.
- cfg_awvalid_o out 1, cfg_awaddr_o out 32, cfg_awready_i in 1: AXI4-Lite write address channel.
- cfg_wvalid_o out 1, cfg_wdata_o out 32, cfg_wstrb_o out 4, cfg_wready_i in 1: write data channel.
- cfg_bvalid_i in 1, cfg_bresp_i in 2, cfg_bready_o out 1: write response channel.
- cfg_arvalid_o out 1, cfg_araddr_o out 32, cfg_arready_i in 1: read address channel.
- cfg_rvalid_i in 1, cfg_rdata_i in 32, cfg_rresp_i in 2, cfg_rready_o out 1: read data channel.
- busy_o out 1: FSM is not in IDLE.

Behaviour:
- Reset:
  - All slots inactive; expired mask = 0; FSM = INIT.
  - All valid outputs = 0; cfg_bready_o = 0; cfg_rready_o = 0; addr/data outputs = 0; cfg_wstrb_o = 4'hF.
- Per-slot state: active bit and 32-bit deadline. Expired mask is NUM_SLOTS bits.
- FSM states:
  - INIT: write CTRL_IDLE to CTRL_ADDR, then IDLE.
  - IDLE:
    - arm_ready_o = 1 only in IDLE.
    - An accepted arm sets the slot active, loads the deadline and clears that slot's expired bit.
    - An accepted cancel clears the slot's active and expired bits.
    - Either sets dirty. Next cycle goes to RD_NOW.
    - irq_i = 1 in IDLE also goes to RD_NOW; arm has priority, and the irq is still seen because irq_i is level and re-sampled.
  - RD_NOW: AR to VAL_ADDR, capture cfg_rdata_i as now, then SCAN.
  - SCAN:
    - Visits one slot per cycle, index 0..NUM_SLOTS-1; NUM_SLOTS cycles total.
    - delta = deadline - now, modulo 2^32.
    - Active slot with delta == 0 or delta[31] == 1: mark expired, clear active.
    - Otherwise track minimum delta; ties go to the lowest index.
  - PROG:
    - If a minimum was found: write its deadline to CMP_ADDR, then CTRL_ARMED to CTRL_ADDR.
    - If none was found: write only CTRL_IDLE to CTRL_ADDR.
  - VERIFY:
    - If an alarm was programmed, read VAL_ADDR again.
    - If the chosen delta is now 0 or negative, go back to SCAN with the new now; this closes the race between scan and program.
    - Otherwise go to IDLE.
- AXI write transaction:
  - AWVALID and WVALID are asserted together in the same cycle. Each is held until its own ready, independently.
  - cfg_bready_o = 1 only after both channels have completed. The transaction ends on bvalid.
- AXI read transaction: ARVALID is held until arready; rready = 1 until rvalid. Latency is not assumed.
- Non-zero bresp/rresp is ignored and the sequence continues.
- Expiry output:
  - expire_id_o = lowest set bit of the expired mask; expire_valid_o = |mask.
  - On valid && ready, that bit clears the same cycle.
  - Bits set in the same cycle as a pop are OR-ed in; no loss.
- Wrap-around: all comparisons use the modular delta, so deadlines up to 2^31-1 ticks ahead are correct across counter wrap.
- Reset mid-transaction: outputs drop immediately (async). The timer slave is assumed to be reset by the same domain.

Optional Feature:
- Macro: TIMER_ALARM_PERIODIC_EN.
- With the macro:
  - Extra port arm_period_i in 32 and a per-slot 32-bit period.
  - A slot expiring in SCAN with non-zero period reloads deadline += period and stays active (the expired bit is still set). It is reconsidered on the next scan.
  - Period 0 = one-shot.
- Without the macro: the port and period storage are absent; all alarms are one-shot.

Decomposition:
- Package timer_alarm_pkg:
  - FSM state enum (INIT, IDLE, RD_NOW, SCAN, PROG, VERIFY).
  - AXI resp constants.
  - Default register addresses and CTRL words.
- Sub-module timer_alarm_axil_mst: a single-outstanding AXI4-Lite master. It takes req/write/addr/wdata, returns done/rdata, and handles the independent AW/W handshake.

Test Plan:
- Reset then idle → exactly one write of CTRL_IDLE (32'h1) to 0x08; busy_o = 0 afterwards; no expire_valid_o.
- now = 100; arm slot 2 deadline 500, slot 1 deadline 300 → CMP = 300, CTRL = 32'h3. Raise irq_i at now = 300 → expire_id_o = 1; then CMP = 500.
- now = 32'hFFFF_FFF0; arm deadline 32'h0000_0010 → treated as future (delta 32); CMP = 32'h10, no immediate expiry.
- Arm deadline = now - 5 → expires in the first SCAN; expire_valid_o = 1, id correct; final CTRL = CTRL_IDLE.
- Slots 0 and 3 expire together, expire_ready_i held low 10 cycles → id 0 is presented first, held stable; then id 3; mask ends at 0.
- Slave delays awready 3 cycles and wready 0 cycles, random arready/rvalid stalls → no duplicate writes, bready only after both channels complete. With TIMER_ALARM_PERIODIC_EN: period 50, deadline 200 → expiries at 200, 250, 300.
